// File: rtl/if_fetch_bp.sv
// Instruction-fetch PC register feeding IF/ID, with a direct-mapped BTB using
// 2-bit saturating counters, trained and redirected by branches resolved in EX.
module if_fetch_bp #(
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        predict_o,
   input  logic        ex_br_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_mispredict,
   output logic        redirect_o
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX - 2;

   logic [31:0]            r_pc;
   logic [BTB_ENTRIES-1:0] r_valid;
   logic [1:0]             r_ctr [BTB_ENTRIES];
   logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
   logic [31:0]            r_tgt [BTB_ENTRIES];

   logic [IDX-1:0]   w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic             w_predict;
   logic [31:0]      w_pred_pc;
   logic [31:0]      w_next_pc;
   logic [IDX-1:0]   w_u_idx;
   logic [TAG_W-1:0] w_u_tag;
   logic             w_u_hit;
   logic             w_redirect;
   logic             w_unused;

   // Lookup on the current fetch PC
   assign w_idx     = r_pc[IDX+1:2];
   assign w_tag     = r_pc[31:IDX+2];
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_predict = w_hit && r_ctr[w_idx][1] && !rst;
   assign w_pred_pc = w_predict ? r_tgt[w_idx] : r_pc + 32'd4;

   assign w_u_idx    = ex_pc[IDX+1:2];
   assign w_u_tag    = ex_pc[31:IDX+2];
   assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
   assign w_redirect = ex_br_valid && ex_mispredict;
   assign w_unused   = ^ex_pc[1:0];

   assign imem_addr  = r_pc;
   assign pc_o       = r_pc;
   assign instr_o    = imem_rdata;
   assign predict_o  = w_predict;
   assign redirect_o = w_redirect;

   always_comb begin
      // NOTE: default assigned first so every path drives it and no latch is inferred.
      w_next_pc = w_pred_pc;
      if (w_redirect) begin
         w_next_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      end else if (!pc_en) begin
         w_next_pc = r_pc;
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_ctr[i] <= 2'b01;
         end
      end else if (ex_br_valid) begin
         if (w_u_hit) begin
            if (ex_taken && (r_ctr[w_u_idx] != 2'b11)) begin
               r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
            end else if (!ex_taken && (r_ctr[w_u_idx] != 2'b00)) begin
               r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
            end
         end else if (ex_taken) begin
            r_valid[w_u_idx] <= 1'b1;
            r_ctr[w_u_idx]   <= 2'b10;
         end
      end
   end

   // NOTE: tag/target arrays have no reset; the valid bits guard them, so they map to plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && ex_br_valid && ex_taken) begin
         r_tag[w_u_idx] <= w_u_tag;
         r_tgt[w_u_idx] <= ex_target;
      end
   end

endmodule

// File: tb/tb_if_fetch_bp.sv
// Scoreboard bench for if_fetch_bp: each step queues the expected fetch state
// for the following cycle and compares it once that cycle is reached.
module tb_if_fetch_bp;

   typedef struct packed {
      logic        rst;
      logic        pc_en;
      logic        bv;
      logic        misp;
      logic        taken;
      logic [31:0] epc;
      logic [31:0] etgt;
      logic [31:0] exp_pc;
      logic        exp_pred;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        predict_o;
   logic        ex_br_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_mispredict;
   logic        redirect_o;

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = imem_word(imem_addr);

   if_fetch_bp dut (
      .clk           (clk),
      .rst           (rst),
      .pc_en         (pc_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc_o          (pc_o),
      .instr_o       (instr_o),
      .predict_o     (predict_o),
      .ex_br_valid   (ex_br_valid),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_mispredict (ex_mispredict),
      .redirect_o    (redirect_o)
   );

   function automatic stim_t mk(input logic r, input logic en, input logic bv, input logic mp,
                                input logic tk, input logic [31:0] epc, input logic [31:0] etgt,
                                input logic [31:0] xpc, input logic xpred);
      stim_t s;
      s = '{rst: r, pc_en: en, bv: bv, misp: mp, taken: tk, epc: epc, etgt: etgt,
            exp_pc: xpc, exp_pred: xpred};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rst           = s.rst;
      pc_en         = s.pc_en;
      ex_br_valid   = s.bv;
      ex_mispredict = s.misp;
      ex_taken      = s.taken;
      ex_pc         = s.epc;
      ex_target     = s.etgt;
   endtask

   // Two reset cycles (one with a redirect + update that reset must override), then sequential fetch.
   task automatic test_reset();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0, 32'h0,   32'h0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 1, 32'h8, 32'h300, 32'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,   32'h4, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,   32'h8, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,   32'hC, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL reset[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL reset[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // Stall, ignored mispredict, redirects under stall (taken / not-taken), PC wrap at 2^32.
   task automatic test_stall_redirect();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,         32'hC,         0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,         32'hC,         0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,    32'h0,         32'hC,         0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'hC,    32'h300,       32'hC,         0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h2000, 32'h100,       32'h100,       0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'h1FC,  32'h0,         32'h200,       0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h1000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,    32'h0,         32'h0,         0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL stall_redirect[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL stall_redirect[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // Allocate 0x10 -> 0x40 while fetching from 0; fetch then follows the prediction.
   task automatic test_btb_alloc();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 1, 1, 0, 1, 32'h10, 32'h40, 32'h4,  0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h8,  0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'hC,  0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h10, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h40, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL btb_alloc[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL btb_alloc[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // 10 -> 01 -> 00, saturate at 00, then 01 -> 10 with a new target; same-index update has no bypass.
   task automatic test_counter();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10, 32'h0,  32'h40, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10, 32'h0,  32'h40, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'hC,  32'h0,  32'h10, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h14, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'hC,  32'h0,  32'h10, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10, 32'h0,  32'h10, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 32'h10, 32'h60, 32'h10, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 32'h10, 32'h60, 32'h10, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h60, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL counter[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL counter[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // 0x50 aliases 0x10 (idx 4): tag miss, then a taken update at 0x50 evicts 0x10.
   task automatic test_alias();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'h4C, 32'h0,  32'h50, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h54, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 32'h50, 32'h80, 32'h54, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'hC,  32'h0,  32'h10, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'h4C, 32'h0,  32'h50, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h80, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL alias[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL alias[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // Reset beats a same-cycle redirect and invalidates every BTB entry.
   task automatic test_reset_mid();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 0, 1, 1, 1, 32'h3000, 32'h200, 32'h0,  0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'hC,    32'h0,   32'h10, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'h4C,   32'h0,   32'h50, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL reset_mid[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL reset_mid[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   // Redirect and BTB allocation in the same cycle both take effect; 0x90 aliases idx 4.
   task automatic test_back_to_back();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, 1, 1, 1, 32'h50, 32'h90, 32'h90, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 32'h4C, 32'h0,  32'h50, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h90, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,  32'h94, 0));
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         n_total++;
         if (redirect_o !== (tbl[i].bv & tbl[i].misp)) begin
            n_bad++;
            $display("FAIL back_to_back[%0d] redirect_o: got %b want %b", i, redirect_o, tbl[i].bv & tbl[i].misp);
         end
         sb.push_back('{pc: tbl[i].exp_pc, pred: tbl[i].exp_pred});
         @(negedge clk);
         e = sb.pop_front();
         n_total++;
         if (pc_o !== e.pc || imem_addr !== e.pc || instr_o !== imem_word(e.pc) || predict_o !== e.pred) begin
            n_bad++;
            $display("FAIL back_to_back[%0d] fetch: got pc=%h addr=%h instr=%h pred=%b want pc=%h instr=%h pred=%b",
                     i, pc_o, imem_addr, instr_o, predict_o, e.pc, imem_word(e.pc), e.pred);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stall_redirect();
      test_btb_alloc();
      test_counter();
      test_alias();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
